// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave : 9-bit (8 data + even parity) SPI mode-0 responder, oversampled
//             into the clk domain, with a one-entry transmit buffer.
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       tx_underrun,
  output logic       busy
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q, ss_prev_d;
  logic [3:0]             count_q, count_d;
  logic [8:0]             tx_sr_q, tx_sr_d;
  logic [8:0]             rx_sr_q, rx_sr_d;
  logic [7:0]             buf_q, buf_d;
  logic                   full_q, full_d;
  logic                   miso_q, miso_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_err_q, rx_err_d;
  logic                   underrun_q, underrun_d;
  logic                   busy_q, busy_d;

  logic       sck_s, ss_s, mosi_s;
  logic       sck_rise, sck_fall, ss_rise, ss_fall;
  logic [8:0] tx_load;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_rise  = ss_s & ~ss_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;
  // An empty buffer at frame start sends 0x00 with parity 0.
  assign tx_load  = full_q ? {^buf_q, buf_q} : 9'h000;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    count_d     = count_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    buf_d       = buf_q;
    full_d      = full_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_err_d    = rx_err_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        miso_d  = 1'b0;
        count_d = 4'd0;
        if (ss_s) state_d = IDLE;
      end
      IDLE: begin
        miso_d  = 1'b0;
        count_d = 4'd0;
        if (ss_fall) begin
          tx_sr_d    = tx_load;
          miso_d     = tx_load[0];
          underrun_d = ~full_q;
          full_d     = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == 4'd9) begin
          rx_data_d  = rx_sr_q[7:0];
          rx_err_d   = ^rx_sr_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          // ss may already be rising in this cycle; its edge is not seen again.
          state_d    = ss_rise ? IDLE : DONE;
        end else if (ss_rise) begin
          miso_d  = 1'b0;
          count_d = 4'd0;
          state_d = IDLE;
        end else if (sck_rise) begin
          rx_sr_d = {mosi_s, rx_sr_q[8:1]};
          count_d = count_q + 4'd1;
        end else if (sck_fall) begin
          miso_d  = tx_sr_q[1];
          tx_sr_d = tx_sr_q >> 1;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (ss_rise) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (tx_valid && !full_q) begin
      buf_d  = tx_data;
      full_d = 1'b1;
    end

    busy_d = (state_d == SHIFT) || (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      state_q     <= WAIT_IDLE;
      count_q     <= 4'd0;
      tx_sr_q     <= 9'h000;
      rx_sr_q     <= 9'h000;
      buf_q       <= 8'h00;
      full_q      <= 1'b0;
      miso_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      count_q     <= count_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      buf_q       <= buf_d;
      full_q      <= full_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign tx_underrun = underrun_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave : bench for spi_slave; bit-banged SPI master, rx scoreboard.
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_slave;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, tx_ready, rx_valid, rx_err, tx_underrun, busy;
  logic [7:0] rx_data;

  spi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rx_cnt = 0;
  int         ur_cnt = 0;
  bit         model_full = 1'b0;
  logic [7:0] model_buf = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    rx_exp_t e;
    if (rx_valid) begin
      rx_cnt++;
      if (rx_q.size() == 0) check("rx_unexpected", 1, 0);
      else begin
        e = rx_q.pop_front();
        check("rx_data", rx_data, e.data);
        check("rx_err", rx_err, e.err);
      end
    end
    if (tx_underrun) ur_cnt++;
  end

  task automatic queue_tx(input logic [7:0] d);
    int k;
    k = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!tx_ready) check("tx_ready_timeout", 0, 1);
    @(negedge clk);
    tx_valid   = 1'b0;
    model_full = 1'b1;
    model_buf  = d;
    check("tx_ready_low", tx_ready, 0);
  endtask

  task automatic check_reset_values(input string where);
    check({where, "_miso"}, miso, 0);
    check({where, "_tx_ready"}, tx_ready, 1);
    check({where, "_rx_data"}, rx_data, 0);
    check({where, "_rx_valid"}, rx_valid, 0);
    check({where, "_rx_err"}, rx_err, 0);
    check({where, "_underrun"}, tx_underrun, 0);
    check({where, "_busy"}, busy, 0);
  endtask

  // One master frame of nbits bits; rst_at < nbits pulses reset before that bit.
  task automatic spi_frame(input logic [8:0] bits, input int nbits, input int rst_at);
    logic [8:0] exp_tx;
    int         rx0, ur0, exp_ur;
    bit         was_reset;
    was_reset = 1'b0;
    rx0 = rx_cnt;
    ur0 = ur_cnt;
    if (model_full) begin
      exp_tx     = {^model_buf, model_buf};
      model_full = 1'b0;
      exp_ur     = 0;
    end else begin
      exp_tx = 9'h000;
      exp_ur = 1;
    end
    mosi = bits[0];
    ss   = 1'b0;
    cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        queue_tx(8'h5A);
        rst = 1'b1;
        cyc(1);
        check_reset_values("midrst");
        rst        = 1'b0;
        model_full = 1'b0;
        was_reset  = 1'b1;
      end
      check($sformatf("miso_bit%0d", i), miso, was_reset ? 1'b0 : exp_tx[i]);
      if (i == 0) check("busy_in_frame", busy, was_reset ? 0 : 1);
      if (i == 8 && !was_reset) rx_q.push_back({bits[7:0], ^bits});
      sck = 1'b1;
      cyc(HALF);
      sck = 1'b0;
      if (i + 1 < nbits) mosi = bits[i+1];
      cyc(HALF);
    end
    ss = 1'b1;
    cyc(12);
    check("rx_count", rx_cnt - rx0, (nbits == 9 && !was_reset) ? 1 : 0);
    check("underrun_count", ur_cnt - ur0, exp_ur);
    check("busy_after", busy, 0);
    check("miso_after", miso, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(4);
    check_reset_values("reset");
    rst = 1'b0;
    cyc(10);

    queue_tx(8'h3C);
    spi_frame({1'b0, 8'hA5}, 9, 99);

    spi_frame({1'b0, 8'h07}, 9, 99);

    spi_frame({1'b1, 8'h01}, 9, 99);

    queue_tx(8'h99);
    spi_frame({1'b0, 8'hF0}, 5, 99);
    spi_frame({1'b0, 8'h81}, 9, 99);

    spi_frame({1'b0, 8'h42}, 9, 3);
    spi_frame({1'b0, 8'h3C}, 9, 99);

    queue_tx(8'h22);
    fork
      spi_frame({1'b0, 8'h55}, 9, 99);
      begin
        cyc(20);
        queue_tx(8'h11);
      end
    join
    spi_frame({1'b0, 8'h66}, 9, 99);

    check("rx_queue_empty", rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
